word_deserializer: RTL and testbench
====================================

# word_deserializer

Collects a serial stream of signed words with a valid/ready handshake and presents each group of four as one parallel frame on WORD_0..WORD_3, the input format of the four-operand adder. It sits directly upstream of the adder: single words go in, and a stable four-word frame comes out with a valid/ready handshake. It buffers one frame in flight, so collection of the next frame overlaps consumption of the current one.

## Interface
- WIDTH, 25: width of every data word, two's-complement signed.
- CLK  in  1  rising-edge clock; the only clock.
- RST  in  1  synchronous, active-high reset, sampled on rising CLK.
- IN_WORD  in  WIDTH  signed input word.
- IN_VALID  in  1  IN_WORD is valid this cycle.
- IN_READY  out  1  block accepts IN_WORD this cycle; combinational.
- ABORT  in  1  synchronous; discards the partially collected frame.
- WORD_0..WORD_3  out  WIDTH each  frame words in arrival order; WORD_0 is first.
- OUT_VALID  out  1  frame on WORD_0..WORD_3 is valid.
- OUT_READY  in  1  consumer takes the frame this cycle.
- COUNT  out  2  number of words held in the collection buffer (0–3).
- CHECK  out  WIDTH  present only with WORD_DESER_CHECK_EN (see Configuration).

## Operation
- Input handshake: a word is accepted on a rising CLK edge when IN_VALID=1 and IN_READY=1.
- Output handshake: a frame is consumed on an edge when OUT_VALID=1 and OUT_READY=1.
- Collection buffer: three WIDTH registers plus COUNT.
- Accepting a word while COUNT<3 stores it at slot COUNT; COUNT increments.
- Accepting a word while COUNT=3 is the frame-completing accept:
  - slots 0–2 and IN_WORD load into the output registers WORD_0..WORD_3;
  - OUT_VALID is set and COUNT returns to 0.
- IN_READY = !(COUNT==3 && OUT_VALID && !OUT_READY).
  - Words 1–3 of a frame are always accepted.
  - Word 4 stalls only while an unconsumed frame is held.
- Simultaneous consume and frame-completing accept on one edge: the new frame loads and OUT_VALID stays 1; no bubble, no loss.
- Consume with no completing accept: OUT_VALID clears; WORD_* keep their last values.
- WORD_* change only on a frame-completing accept or on reset; they are stable while OUT_VALID=1.
- ABORT=1 sets COUNT to 0 and discards buffered words.
  - OUT_VALID and WORD_* are unaffected.
  - ABORT has priority over an accept on the same edge: that word is discarded and never completes a frame.
  - IN_READY is not gated by ABORT.
- Reset: COUNT=0, OUT_VALID=0, WORD_0..WORD_3=0, CHECK=0, collection slots=0.
  - Reset has priority over all other inputs.
  - Reset mid-frame or with a pending output frame discards both.

## Timing
- OUT_VALID rises on the same edge that accepts word 4; latency from the word-4 accept to a visible frame is 0 cycles after that edge.
- Sustained throughput is one word per cycle. With OUT_READY held at 1, one frame completes every 4 cycles.
- IN_READY has a combinational path from OUT_READY, and from registered COUNT and OUT_VALID only. There is no IN_VALID→IN_READY path.
- All outputs except IN_READY are registered.

## Configuration
- WORD_DESER_CHECK_EN defined:
  - CHECK port exists; it is registered and loaded on the same edge as WORD_*.
  - CHECK = WORD_0+WORD_1+WORD_2+WORD_3, truncated to WIDTH bits, i.e. two's-complement wrap. This is the reference value for comparing against the adder RES.
- WORD_DESER_CHECK_EN undefined: the CHECK port and its adder logic are absent; all other behaviour is identical.

## Test plan
- Basic frame: reset, then words 1,2,3,4 on consecutive cycles with OUT_READY=1 → IN_READY=1 throughout; OUT_VALID=1 for one cycle; WORD_0..3=1,2,3,4; CHECK=10.
- Signed values: words -1,0,5,0 → WORD_0=-1, WORD_2=5, CHECK=4. Then 16777215,1,0,0 → CHECK=-16777216 (wrap).
- Backpressure: OUT_READY=0, two frames 1..4 then 5..8 streamed.
  - After 5,6,7 accepted, COUNT=3 and IN_READY=0; word 8 is held; WORD_* stay 1..4.
  - Raise OUT_READY → 8 is accepted on that edge; WORD_*=5..8; OUT_VALID stays 1.
- Back-to-back: 12 words continuous with OUT_READY=1 → three frames on cycles 4, 8 and 12 after the start; no IN_READY deassertion.
- ABORT: words 9,9 accepted, then ABORT together with IN_VALID carrying 7 → COUNT=0, the 7 is dropped. Next 1,2,3,4 → frame 1,2,3,4.
- Reset mid-operation: pending frame held (OUT_READY=0) and COUNT=2, assert RST one cycle → OUT_VALID=0, COUNT=0, WORD_*=0, CHECK=0. Next 4 words form a fresh frame.

Source files
------------

// File: rtl/word_deserializer_if.sv
// word_deserializer_if: handshake/bus bundle for word_deserializer.
//   slave  modport : the deserializer (consumes IN_*, drives frame side)
//   master modport : the upstream/downstream environment
// Signals:
//   IN_WORD/IN_VALID/IN_READY  serial word stream in, valid/ready
//   ABORT                      drop the partially collected frame
//   WORD_0..WORD_3             parallel frame out, WORD_0 arrived first
//   OUT_VALID/OUT_READY        frame handshake
//   COUNT                      words held in the collection buffer
//   CHECK                      wrapped sum of the frame (WORD_DESER_CHECK_EN only)
interface word_deserializer_if #(
  parameter int WIDTH = 25
);
  logic [WIDTH-1:0] IN_WORD;
  logic             IN_VALID;
  logic             IN_READY;
  logic             ABORT;
  logic [WIDTH-1:0] WORD_0;
  logic [WIDTH-1:0] WORD_1;
  logic [WIDTH-1:0] WORD_2;
  logic [WIDTH-1:0] WORD_3;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [1:0]       COUNT;
`ifdef WORD_DESER_CHECK_EN
  logic [WIDTH-1:0] CHECK;
`endif

  modport slave (
    input  IN_WORD, IN_VALID, ABORT, OUT_READY,
    output IN_READY, WORD_0, WORD_1, WORD_2, WORD_3, OUT_VALID, COUNT
`ifdef WORD_DESER_CHECK_EN
    , output CHECK
`endif
  );

  modport master (
    output IN_WORD, IN_VALID, ABORT, OUT_READY,
    input  IN_READY, WORD_0, WORD_1, WORD_2, WORD_3, OUT_VALID, COUNT
`ifdef WORD_DESER_CHECK_EN
    , input CHECK
`endif
  );
endinterface

// File: rtl/word_deserializer.sv
// word_deserializer: gathers four serial signed words into one parallel frame
// for the four-operand adder. Three collection slots plus a registered output
// frame give one frame of overlap: the next frame is collected while the
// current one waits to be consumed.
// Ports:
//   CLK  rising-edge clock
//   RST  synchronous active-high reset, highest priority
//   bus  word_deserializer_if.slave (see interface header for signals)
// Optional feature: define WORD_DESER_CHECK_EN to add the registered CHECK
// output (WIDTH-bit wrapped sum of the frame, loaded with WORD_*).
module word_deserializer #(
  parameter int WIDTH = 25
) (
  input logic               CLK,
  input logic               RST,
  word_deserializer_if.slave bus
);

  logic [1:0]            count_q, count_d;
  logic [2:0][WIDTH-1:0] slot_q, slot_d;
  logic [3:0][WIDTH-1:0] word_q, word_d;
  logic                  out_valid_q, out_valid_d;
`ifdef WORD_DESER_CHECK_EN
  logic [WIDTH-1:0]      check_q, check_d;
`endif

  logic in_ready;
  logic accept;
  logic complete;

  // Only the fourth word can stall, and only while the held frame is not
  // being taken this cycle. No dependence on IN_VALID or ABORT.
  assign in_ready = !(count_q == 2'd3 && out_valid_q && !bus.OUT_READY);
  assign accept   = bus.IN_VALID && in_ready;
  // ABORT wins over an accept on the same edge, so the word never completes.
  assign complete = accept && !bus.ABORT && count_q == 2'd3;

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      count_q     <= '0;
      slot_q      <= '0;
      word_q      <= '0;
      out_valid_q <= 1'b0;
`ifdef WORD_DESER_CHECK_EN
      check_q     <= '0;
`endif
    end else begin
      count_q     <= count_d;
      slot_q      <= slot_d;
      word_q      <= word_d;
      out_valid_q <= out_valid_d;
`ifdef WORD_DESER_CHECK_EN
      check_q     <= check_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    count_d     = count_q;
    slot_d      = slot_q;
    word_d      = word_q;
    out_valid_d = out_valid_q;
`ifdef WORD_DESER_CHECK_EN
    check_d     = check_q;
`endif

    if (bus.ABORT) begin
      count_d = '0;
    end else if (accept) begin
      if (count_q == 2'd3) begin
        word_d  = {bus.IN_WORD, slot_q[2], slot_q[1], slot_q[0]};
        count_d = '0;
`ifdef WORD_DESER_CHECK_EN
        check_d = slot_q[0] + slot_q[1] + slot_q[2] + bus.IN_WORD;
`endif
      end else begin
        case (count_q)
          2'd0:    slot_d[0] = bus.IN_WORD;
          2'd1:    slot_d[1] = bus.IN_WORD;
          default: slot_d[2] = bus.IN_WORD;
        endcase
        count_d = count_q + 2'd1;
      end
    end

    // A completing accept refills the output even if the old frame is taken
    // on the same edge, so a consume only clears valid when nothing new lands.
    if (complete)
      out_valid_d = 1'b1;
    else if (out_valid_q && bus.OUT_READY)
      out_valid_d = 1'b0;
  end

  // Outputs
  assign bus.IN_READY  = in_ready;
  assign bus.WORD_0    = word_q[0];
  assign bus.WORD_1    = word_q[1];
  assign bus.WORD_2    = word_q[2];
  assign bus.WORD_3    = word_q[3];
  assign bus.OUT_VALID = out_valid_q;
  assign bus.COUNT     = count_q;
`ifdef WORD_DESER_CHECK_EN
  assign bus.CHECK     = check_q;
`endif

endmodule

// File: tb/tb_word_deserializer.sv
module tb_word_deserializer;
  localparam int W = 25;

  logic CLK = 1'b0;
  logic RST;
  int   n_chk  = 0;
  int   n_fail = 0;

  word_deserializer_if #(.WIDTH(W)) bus ();

  word_deserializer #(.WIDTH(W)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Present one word, confirm it is ready, let it be accepted.
  task automatic push(input logic [W-1:0] w);
    bus.IN_WORD  = w;
    bus.IN_VALID = 1'b1;
    #1;
    chk("in_ready", W'(bus.IN_READY), W'(1));
    tick();
    bus.IN_VALID = 1'b0;
  endtask

  task automatic chk_frame(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] c, input logic [W-1:0] d);
    chk({tag, ".w0"}, bus.WORD_0, a);
    chk({tag, ".w1"}, bus.WORD_1, b);
    chk({tag, ".w2"}, bus.WORD_2, c);
    chk({tag, ".w3"}, bus.WORD_3, d);
  endtask

  initial begin
    RST           = 1'b1;
    bus.IN_WORD   = '0;
    bus.IN_VALID  = 1'b0;
    bus.ABORT     = 1'b0;
    bus.OUT_READY = 1'b1;
    tick();
    tick();
    RST = 1'b0;

    // Reset state
    chk("rst.count", W'(bus.COUNT), W'(0));
    chk("rst.valid", W'(bus.OUT_VALID), W'(0));
    chk_frame("rst", 0, 0, 0, 0);
    chk("rst.in_ready", W'(bus.IN_READY), W'(1));

    // Basic frame
    push(1); push(2); push(3);
    chk("basic.count3", W'(bus.COUNT), W'(3));
    chk("basic.valid_pre", W'(bus.OUT_VALID), W'(0));
    push(4);
    chk("basic.valid", W'(bus.OUT_VALID), W'(1));
    chk("basic.count0", W'(bus.COUNT), W'(0));
    chk_frame("basic", 1, 2, 3, 4);
`ifdef WORD_DESER_CHECK_EN
    chk("basic.check", bus.CHECK, W'(10));
`endif
    tick();
    chk("basic.consumed", W'(bus.OUT_VALID), W'(0));
    chk_frame("basic.hold", 1, 2, 3, 4);

    // Signed values and wrap
    push(W'(-1)); push(0); push(5); push(0);
    chk("signed.valid", W'(bus.OUT_VALID), W'(1));
    chk_frame("signed", W'(-1), 0, 5, 0);
`ifdef WORD_DESER_CHECK_EN
    chk("signed.check", bus.CHECK, W'(4));
`endif
    tick();
    push(W'(16777215)); push(1); push(0); push(0);
    chk_frame("wrap", W'(16777215), 1, 0, 0);
`ifdef WORD_DESER_CHECK_EN
    chk("wrap.check", bus.CHECK, W'(-16777216));
`endif
    tick();

    // Backpressure
    bus.OUT_READY = 1'b0;
    push(1); push(2); push(3); push(4);
    push(5); push(6); push(7);
    chk("bp.count3", W'(bus.COUNT), W'(3));
    bus.IN_WORD  = 8;
    bus.IN_VALID = 1'b1;
    #1;
    chk("bp.stall", W'(bus.IN_READY), W'(0));
    tick();
    chk("bp.held.count", W'(bus.COUNT), W'(3));
    chk("bp.held.valid", W'(bus.OUT_VALID), W'(1));
    chk_frame("bp.held", 1, 2, 3, 4);
    bus.OUT_READY = 1'b1;
    #1;
    chk("bp.release", W'(bus.IN_READY), W'(1));
    tick();
    bus.IN_VALID = 1'b0;
    chk("bp.new.valid", W'(bus.OUT_VALID), W'(1));
    chk("bp.new.count", W'(bus.COUNT), W'(0));
    chk_frame("bp.new", 5, 6, 7, 8);
    tick();
    chk("bp.drain", W'(bus.OUT_VALID), W'(0));

    // Back-to-back: 12 words, frames visible after cycles 4, 8, 12
    for (int i = 1; i <= 12; i++) begin
      push(W'(100 + i));
      chk($sformatf("b2b.valid%0d", i), W'(bus.OUT_VALID), W'(i % 4 == 0));
      if (i % 4 == 0)
        chk_frame($sformatf("b2b.f%0d", i / 4), W'(97 + i), W'(98 + i), W'(99 + i), W'(100 + i));
    end
    tick();

    // ABORT drops buffered words and the word accepted alongside it
    push(9); push(9);
    chk("abort.count2", W'(bus.COUNT), W'(2));
    bus.ABORT    = 1'b1;
    bus.IN_WORD  = 7;
    bus.IN_VALID = 1'b1;
    #1;
    chk("abort.in_ready", W'(bus.IN_READY), W'(1));
    tick();
    bus.ABORT    = 1'b0;
    bus.IN_VALID = 1'b0;
    chk("abort.count0", W'(bus.COUNT), W'(0));
    chk("abort.valid", W'(bus.OUT_VALID), W'(0));
    push(1); push(2); push(3); push(4);
    chk("abort.frame.valid", W'(bus.OUT_VALID), W'(1));
    chk_frame("abort.frame", 1, 2, 3, 4);
    tick();

    // Reset with a pending frame and two buffered words
    bus.OUT_READY = 1'b0;
    push(21); push(22); push(23); push(24);
    push(25); push(26);
    chk("mrst.pre.count", W'(bus.COUNT), W'(2));
    chk("mrst.pre.valid", W'(bus.OUT_VALID), W'(1));
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("mrst.count", W'(bus.COUNT), W'(0));
    chk("mrst.valid", W'(bus.OUT_VALID), W'(0));
    chk_frame("mrst", 0, 0, 0, 0);
`ifdef WORD_DESER_CHECK_EN
    chk("mrst.check", bus.CHECK, W'(0));
`endif
    push(11); push(12); push(13);
    chk("mrst.fresh.valid_pre", W'(bus.OUT_VALID), W'(0));
    push(14);
    chk("mrst.fresh.valid", W'(bus.OUT_VALID), W'(1));
    chk_frame("mrst.fresh", 11, 12, 13, 14);
`ifdef WORD_DESER_CHECK_EN
    chk("mrst.fresh.check", bus.CHECK, W'(50));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
